// File: rtl/vx_warp_issue_sched.sv
// ============================================================================
// vx_warp_issue_sched : per-core warp issue scheduler (round-robin + starvation)
// Revision 1.0
// ============================================================================
`default_nettype none

module vx_warp_issue_sched #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_EX       = 5,
  parameter int EX_BITS      = 3,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_WARPS-1:0]         warp_valid,
  input  logic [NUM_WARPS*EX_BITS-1:0] warp_ex_type,
  output logic [NUM_WARPS-1:0]         warp_ready,
  input  logic [NUM_EX-1:0]            ex_ready,
  output logic                         issue_valid,
  output logic [$clog2(NUM_WARPS)-1:0] issue_wid,
  output logic [EX_BITS-1:0]           issue_ex_type,
  input  logic                         issue_ready,
  output logic [31:0]                  perf_stall_cycles,
  output logic [31:0]                  perf_issue_count
);

  localparam int WID_BITS = $clog2(NUM_WARPS);

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] starving;
  logic [7:0]           age [NUM_WARPS];
  logic [WID_BITS-1:0]  rr_ptr;
  logic                 load;
  logic                 starve_hit;
  logic [WID_BITS-1:0]  starve_idx;
  logic [WID_BITS-1:0]  rr_idx;
  logic [WID_BITS-1:0]  cand;
  logic [WID_BITS-1:0]  grant_idx;
  logic [EX_BITS-1:0]   grant_ex;
  logic                 grant_valid;

  assign load = !issue_valid || issue_ready;

  // Out-of-range ex_type is a NOP and never waits on a unit.
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_elig
    logic [EX_BITS-1:0] ex;
    logic               unit_rdy;
    assign ex = warp_ex_type[w*EX_BITS +: EX_BITS];
    always_comb begin
      unit_rdy = 1'b1;
      for (int e = 0; e < NUM_EX; e++) begin
        if (ex == EX_BITS'(e)) unit_rdy = ex_ready[e];
      end
    end
    assign eligible[w] = warp_valid[w] && unit_rdy;
    assign starving[w] = eligible[w] && (age[w] >= 8'(STARVE_LIMIT));
  end

  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int w = NUM_WARPS - 1; w >= 0; w--) begin
      if (starving[w]) begin
        starve_hit = 1'b1;
        starve_idx = WID_BITS'(w);
      end
    end
    // Descending scan so the closest eligible warp at/after rr_ptr wins.
    rr_idx = '0;
    cand   = '0;
    for (int k = NUM_WARPS - 1; k >= 0; k--) begin
      cand = rr_ptr + WID_BITS'(k);
      if (eligible[cand]) rr_idx = cand;
    end
    grant_idx   = starve_hit ? starve_idx : rr_idx;
    grant_valid = reset && load && (|eligible);
    grant_ex    = '0;
    warp_ready  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (grant_idx == WID_BITS'(w)) begin
        grant_ex      = warp_ex_type[w*EX_BITS +: EX_BITS];
        warp_ready[w] = grant_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid       <= 1'b0;
      issue_wid         <= '0;
      issue_ex_type     <= '0;
      rr_ptr            <= '0;
      perf_stall_cycles <= '0;
      perf_issue_count  <= '0;
    end else begin
      if (load) begin
        issue_valid <= grant_valid;
        if (grant_valid) begin
          issue_wid     <= grant_idx;
          issue_ex_type <= grant_ex;
          rr_ptr        <= grant_idx + WID_BITS'(1);
        end
      end
      if ((|warp_valid) && !grant_valid && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (issue_valid && issue_ready && (perf_issue_count != 32'hFFFF_FFFF))
        perf_issue_count <= perf_issue_count + 32'd1;
    end
  end

  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_age
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        age[w] <= '0;
      end else if (!warp_valid[w] || warp_ready[w]) begin
        age[w] <= '0;
      end else if (age[w] != 8'hFF) begin
        age[w] <= age[w] + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vx_warp_issue_sched.sv
// Testbench for vx_warp_issue_sched: scoreboard against a behavioural model.
`default_nettype none

module tb_vx_warp_issue_sched;

  localparam int NW = 4;
  localparam int NE = 5;
  localparam int EB = 3;
  localparam int SL = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [NW-1:0] warp_valid;
  logic [NW*EB-1:0] warp_ex_type;
  logic [NW-1:0] warp_ready;
  logic [NE-1:0] ex_ready;
  logic          issue_valid;
  logic [1:0]    issue_wid;
  logic [EB-1:0] issue_ex_type;
  logic          issue_ready;
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_issue_count;

  always #5 clk = ~clk;

  vx_warp_issue_sched #(.NUM_WARPS(NW), .NUM_EX(NE), .EX_BITS(EB), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .warp_valid(warp_valid), .warp_ex_type(warp_ex_type), .warp_ready(warp_ready),
    .ex_ready(ex_ready),
    .issue_valid(issue_valid), .issue_wid(issue_wid), .issue_ex_type(issue_ex_type),
    .issue_ready(issue_ready),
    .perf_stall_cycles(perf_stall_cycles), .perf_issue_count(perf_issue_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {int wid; int ex;} exp_t;
  exp_t sbq[$];
  exp_t popped;

  // Reference state: what the scheduler should hold after each edge.
  int     m_valid, m_wid, m_ex, m_rr;
  int     m_age[NW];
  longint m_stall, m_issued;

  task automatic check(string name, longint act, longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_valid = 0; m_wid = 0; m_ex = 0; m_rr = 0;
    foreach (m_age[w]) m_age[w] = 0;
    m_stall = 0; m_issued = 0;
    sbq.delete();
  endtask

  task automatic model_step();
    int ex[NW];
    bit elig[NW];
    int g;
    bit load;
    check("issue_valid", issue_valid, m_valid);
    if (m_valid != 0) begin
      check("issue_wid_held", issue_wid, m_wid);
      check("issue_ex_held", issue_ex_type, m_ex);
    end
    check("perf_stall_cycles", perf_stall_cycles, m_stall);
    check("perf_issue_count", perf_issue_count, m_issued);
    load = (m_valid == 0) || issue_ready;
    for (int w = 0; w < NW; w++) begin
      ex[w]   = int'(warp_ex_type[w*EB +: EB]);
      elig[w] = warp_valid[w] && ((ex[w] >= NE) ? 1'b1 : ex_ready[ex[w]]);
    end
    g = -1;
    if (load) begin
      for (int w = 0; w < NW; w++)
        if (g < 0 && elig[w] && m_age[w] >= SL) g = w;
      for (int k = 0; k < NW; k++)
        if (g < 0 && elig[(m_rr + k) % NW]) g = (m_rr + k) % NW;
    end
    check("warp_ready", warp_ready, (g >= 0) ? (1 << g) : 0);
    if (warp_valid != 0 && g < 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (m_valid != 0 && issue_ready && m_issued < 64'hFFFF_FFFF) m_issued++;
    if (load) begin
      if (g >= 0) begin
        m_valid = 1; m_wid = g; m_ex = ex[g]; m_rr = (g + 1) % NW;
        sbq.push_back('{g, ex[g]});
      end else begin
        m_valid = 0;
      end
    end
    for (int w = 0; w < NW; w++) begin
      if (!warp_valid[w] || w == g) m_age[w] = 0;
      else if (m_age[w] < 255) m_age[w]++;
    end
  endtask

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(logic [NW-1:0] v, logic [NW*EB-1:0] ex, logic [NE-1:0] er, logic ir);
    warp_valid = v; warp_ex_type = ex; ex_ready = er; issue_ready = ir;
  endtask

  // Monitor: every accepted transfer must match the oldest predicted grant.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && issue_valid && issue_ready) begin
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_empty actual_wid=%0d required=none @%0t", issue_wid, $time);
        end else begin
          popped = sbq.pop_front();
          check("sb_wid", issue_wid, popped.wid);
          check("sb_ex_type", issue_ex_type, popped.ex);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drive(4'hF, '0, 5'h1F, 1'b1);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_warp_ready", warp_ready, 0);
      check("rst_issue_valid", issue_valid, 0);
      check("rst_issue_wid", issue_wid, 0);
      check("rst_perf_stall", perf_stall_cycles, 0);
      check("rst_perf_issue", perf_issue_count, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    // Round-robin over all warps.
    cyc(9);
    // Warps 0,1 on LSU (blocked), warp 2 on ALU.
    drive(4'b0111, {3'd0, 3'd0, 3'd1, 3'd1}, 5'b00001, 1'b1);
    cyc(5);
    drive(4'b0111, {3'd0, 3'd0, 3'd1, 3'd1}, 5'b00011, 1'b1);
    cyc(6);
    // Backpressure for three cycles with all warps valid.
    drive(4'hF, '0, 5'h1F, 1'b1);
    cyc(2);
    issue_ready = 1'b0; cyc(3);
    issue_ready = 1'b1; cyc(4);
    // Long stall so every warp starves; the lowest index must win over rr.
    drive(4'hF, '0, 5'h1F, 1'b1);
    cyc(2);
    issue_ready = 1'b0; cyc(18);
    issue_ready = 1'b1; cyc(8);
    // NOP ex_type with all units blocked.
    drive(4'hF, {4{3'd7}}, 5'b00000, 1'b1);
    cyc(6);

    // Random traffic with sticky valids so starvation can arise.
    drive(4'hF, '0, 5'h1F, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) warp_valid = 4'($urandom);
      if ($urandom_range(0, 5) == 0) warp_ex_type = 12'($urandom);
      ex_ready    = 5'($urandom);
      issue_ready = ($urandom_range(0, 9) < 6);
      cyc(1);
    end

    // Asynchronous reset in the middle of a cycle.
    #2;
    reset = 1'b0;
    #1;
    check("async_issue_valid", issue_valid, 0);
    check("async_warp_ready", warp_ready, 0);
    check("async_perf_stall", perf_stall_cycles, 0);
    check("async_perf_issue", perf_issue_count, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 600; i++) begin
      warp_valid   = 4'($urandom);
      warp_ex_type = 12'($urandom);
      ex_ready     = 5'($urandom);
      issue_ready  = ($urandom_range(0, 3) != 0);
      cyc(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vx_warp_issue_sched.md
Name: vx_warp_issue_sched

Overview:
- Per-core issue scheduler between the per-warp instruction buffers and the dispatch stage.
- Each cycle it picks at most one warp whose head instruction targets an execution unit (ALU/LSU/CSR/FPU/GPU) whose dispatch skid buffer can accept.
- Selection is round-robin with starvation override.
- Presents the selected warp id and ex_type on a registered valid/ready channel, and keeps stall/issue performance counters.

Parameters:
- NUM_WARPS, 4, number of warps (power of two, >=2).
- NUM_EX, 5, number of execution-unit classes; ex_type codes 0..NUM_EX-1.
- EX_BITS, 3, width of ex_type.
- STARVE_LIMIT, 15, wait cycles after which a warp gains starvation priority (1..255).

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset (0 = reset asserted).
- warp_valid, in, NUM_WARPS, per-warp head-instruction valid.
- warp_ex_type, in, NUM_WARPS*EX_BITS, per-warp head ex_type; warp w occupies bits [w*EX_BITS +: EX_BITS].
- warp_ready, out, NUM_WARPS, one-hot pop strobe to the granted warp's buffer.
- ex_ready, in, NUM_EX, per-unit ready from dispatch.
- issue_valid, out, 1, registered issue valid.
- issue_wid, out, log2(NUM_WARPS), registered warp id.
- issue_ex_type, out, EX_BITS, registered ex_type.
- issue_ready, in, 1, downstream accept.
- perf_stall_cycles, out, 32, count of cycles where a warp was valid but none was granted.
- perf_issue_count, out, 32, count of accepted issues.

Behaviour:
- Reset (reset=0, async): issue_valid=0, issue_wid=0, issue_ex_type=0, rr pointer=0, all age counters=0, perf counters=0. warp_ready=0 throughout reset.
- Eligibility: eligible[w] = warp_valid[w] && (ex_type >= NUM_EX ? 1 : ex_ready[ex_type]). Out-of-range ex_type is a NOP and is always eligible.
- Load condition: load = !issue_valid || issue_ready. The output register is a single pipeline stage; it holds its value when load=0.
- Grant:
  - Only computed when load=1.
  - If any eligible warp has age >= STARVE_LIMIT, grant the lowest-index such warp.
  - Otherwise grant the first eligible warp scanning from rr pointer upward, wrapping modulo NUM_WARPS.
  - No eligible warp: no grant.
- On grant g:
  - warp_ready[g]=1 combinationally in the same cycle.
  - Next edge: issue_valid<=1, issue_wid<=g, issue_ex_type<=warp_ex_type[g].
  - rr pointer <= (g+1) mod NUM_WARPS; wrap from NUM_WARPS-1 goes to 0.
- On load with no grant: issue_valid<=0 next edge.
- Latency: grant cycle N gives issue_valid at N+1. Back-to-back issue every cycle while issue_ready=1.
- Age counters:
  - Per warp, 8 bits.
  - Cleared when the warp is granted or warp_valid[w]=0.
  - Otherwise incremented each cycle, saturating at 255.
- perf_stall_cycles: increments when |warp_valid && !(load && grant). Saturates at 0xFFFFFFFF.
- perf_issue_count: increments when issue_valid && issue_ready. Saturates at 0xFFFFFFFF.
- Simultaneous events:
  - Downstream accept and new grant in the same cycle: the register reloads with no bubble.
  - ex_ready drop while a warp is already latched in the output register does not cancel the latched issue.
- warp_valid drop without a pop is legal. The warp simply loses eligibility and its age clears.
- Reset asserted mid-operation: outputs clear immediately (async); a pending issue is discarded.

Test Plan:
- Reset: hold reset=0 with all warp_valid=1 -> issue_valid=0, warp_ready=0, counters 0. Release -> first grant wid=0 at the next edge, issue_valid=1 one cycle later.
- Round-robin: NUM_WARPS=4, all valid, ex_type=0, ex_ready=all 1, issue_ready=1 -> issue_wid sequence 0,1,2,3,0 with one issue per cycle.
- Unit-blocked skip:
  - warps 0,1 target LSU(1), warp 2 targets ALU(0), ex_ready=5'b00001 -> only wid 2 issues.
  - Raise ex_ready[1] -> warps 0,1 then issue.
- Backpressure: issue_ready=0 for 3 cycles after issue of wid 1 -> issue_wid stays 1, warp_ready=0, perf_stall_cycles +3 while other warps are valid.
- Starvation: warp 3 eligible but kept losing by forcing the rr pointer past it via other warps; after 15 waiting cycles -> warp 3 granted ahead of the rr choice and its age clears.
- NOP ex_type=7 with ex_ready=0 -> still granted; perf_issue_count increments on accept.
